// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux drive sequencer.
// Request layout, FSM state encoding and scan-pointer stepping.
package demux_seq_pkg;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned REQ_W  = 1 + SEL_W;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StGap   = 2'd2
   } state_e;

   typedef struct packed {
      logic             data;
      logic [SEL_W-1:0] sel;
   } req_t;

   // Scan pointer walks 0..NUM_CH-1 and wraps.
   function automatic logic [SEL_W-1:0] next_scan(input logic [SEL_W-1:0] ptr);
      if (ptr == SEL_W'(NUM_CH - 1)) begin
         return '0;
      end
      return ptr + SEL_W'(1);
   endfunction

endpackage

// File: rtl/demux_8x1.sv
// 1-to-8 demultiplexer: routes a_i onto y_o[sel_i], all other outputs low.
module demux_8x1
   import demux_seq_pkg::*;
(
   input  logic              a_i,
   input  logic [SEL_W-1:0]  sel_i,
   output logic [NUM_CH-1:0] y_o
);

   always_comb begin
      y_o        = '0;
      y_o[sel_i] = a_i;
   end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous active-high reset.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
   parameter int unsigned Width = 4,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned CountW = PtrW + 1;

   logic [Width-1:0]  mem_q [Depth];
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [CountW-1:0] count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CountW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) begin
         wptr_d = wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CountW'(push_ok) - CountW'(pop_ok);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; only entries below count_q are ever read.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/demux_drive_seq.sv
// Upstream driver for demux_8x1: queues (data, channel) requests and drives a/sel with a
// fixed dwell and guard gap, auto-sweeping all channels when idle and scan_en is set.
module demux_drive_seq
   import demux_seq_pkg::*;
#(
   parameter int unsigned DWELL      = 4,
   parameter int unsigned GAP        = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_data,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             scan_en,
   output logic             a,
   output logic [SEL_W-1:0] sel,
   output logic             drv_active,
   output logic             done,
   output logic             busy
);

   localparam int unsigned CntMax  = (DWELL > GAP) ? DWELL : GAP;
   localparam int unsigned CntW    = $clog2(CntMax) + 1;
   localparam int unsigned CountW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL - 1);
   localparam logic [CntW-1:0] GapLoad   = (GAP > 0) ? CntW'(GAP - 1) : CntW'(0);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             a_q, a_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

   req_t             in_req, head_req;
   logic [REQ_W-1:0] head_raw;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CountW-1:0] fifo_count;

   assign in_req    = '{data: in_data, sel: in_sel};
   assign head_req  = req_t'(head_raw);
   // Ready comes from the registered fill level only, so a same-cycle pop never frees a slot.
   assign in_ready  = !fifo_full && !rst;
   assign fifo_push = in_valid && in_ready;

   sync_fifo #(
      .Width (REQ_W),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .data_i  (in_req),
      .pop_i   (fifo_pop),
      .data_o  (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      sel_d      = sel_q;
      scan_ptr_d = scan_ptr_q;
      fifo_pop   = 1'b0;
      unique case (state_q)
         StIdle: begin
            a_d = 1'b0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               a_d      = head_req.data;
               sel_d    = head_req.sel;
               cnt_d    = DwellLoad;
               state_d  = StDrive;
            end else if (scan_en) begin
               a_d        = 1'b1;
               sel_d      = scan_ptr_q;
               scan_ptr_d = next_scan(scan_ptr_q);
               cnt_d      = DwellLoad;
               state_d    = StDrive;
            end
         end
         StDrive: begin
            if (cnt_q == '0) begin
               a_d = 1'b0;
               if (GAP > 0) begin
                  cnt_d   = GapLoad;
                  state_d = StGap;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            a_d     = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         a_q        <= 1'b0;
         sel_q      <= '0;
         scan_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         sel_q      <= sel_d;
         scan_ptr_q <= scan_ptr_d;
      end
   end

   assign a          = a_q;
   assign sel        = sel_q;
   assign drv_active = (state_q == StDrive);
   // Suppressed under reset: an aborted drive never reports completion.
   assign done       = drv_active && (cnt_q == '0) && !rst;
   assign busy       = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_demux_drive_seq.sv
// Directed bench for demux_drive_seq: default timing instance plus a DWELL=1/GAP=0 instance,
// with a demux_8x1 on the default instance's outputs.
module tb_demux_drive_seq;
   import demux_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid, in_data, scan_en;
   logic [2:0] in_sel;
   logic       in_ready, a, drv_active, done, busy;
   logic [2:0] sel;
   logic [7:0] y;

   logic       v2, d2, scan2;
   logic [2:0] sel2i;
   logic       rdy2, a2, act2, done2, busy2;
   logic [2:0] sel2;

   int total = 0;
   int bad   = 0;

   demux_drive_seq #(.DWELL(4), .GAP(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .scan_en(scan_en), .a(a), .sel(sel), .drv_active(drv_active),
      .done(done), .busy(busy)
   );

   demux_drive_seq #(.DWELL(1), .GAP(0), .FIFO_DEPTH(4)) dut_b2b (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
      .in_sel(sel2i), .scan_en(scan2), .a(a2), .sel(sel2), .drv_active(act2),
      .done(done2), .busy(busy2)
   );

   demux_8x1 u_demux (.a_i(a), .sel_i(sel), .y_o(y));

   // Demux scoreboard: while driving, only y[sel] may carry a; every other output is 0.
   always @(negedge clk) begin
      if (!rst && drv_active) begin
         total++;
         if (y[sel] !== a || (y & ~(8'd1 << sel)) !== 8'd0) begin
            bad++;
            $display("FAIL demux_scoreboard: y=%b, required only y[%0d]=%b", y, sel, a);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if (a !== 1'b0 || sel !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || drv_active !== 1'b0
          || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: a=%b sel=%0d done=%b busy=%b act=%b rdy=%b, required 0 0 0 0 0 1",
                  a, sel, done, busy, drv_active, in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b1; in_data = 1'b1; in_sel = 3'd6;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (drv_active !== 1'b1 || a !== 1'b1 || sel !== 3'd6) begin
         bad++;
         $display("FAIL reset_pre_drive: act=%b a=%b sel=%0d, required 1 1 6", drv_active, a, sel);
      end
      @(posedge clk); #1 rst = 1'b1; in_valid = 1'b1; in_data = 1'b1; in_sel = 3'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_%0d: rdy=%b done=%b, required 0 0", i, in_ready, done);
         end
         if (i > 0) begin
            total++;
            if (a !== 1'b0 || sel !== 3'd0 || drv_active !== 1'b0) begin
               bad++;
               $display("FAIL reset_abort_%0d: a=%b sel=%0d act=%b, required 0 0 0",
                        i, a, sel, drv_active);
            end
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1 || busy !== 1'b0 || drv_active !== 1'b0 || done !== 1'b0
             || a !== 1'b0 || sel !== 3'd0) begin
            bad++;
            $display("FAIL reset_release_%0d: rdy=%b busy=%b act=%b done=%b a=%b sel=%0d",
                     i, in_ready, busy, drv_active, done, a, sel);
         end
      end
   endtask

   task automatic test_single();
      int   done_cnt = 0;
      logic exp_a, exp_done;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k == 0);
         in_data  = 1'b1;
         in_sel   = 3'd5;
         @(negedge clk);
         exp_a    = (k >= 2 && k <= 5);
         exp_done = (k == 5);
         total++;
         if (a !== exp_a || done !== exp_done || drv_active !== exp_a) begin
            bad++;
            $display("FAIL single_t%0d: a=%b done=%b act=%b, required %b %b %b",
                     k, a, done, drv_active, exp_a, exp_done, exp_a);
         end
         if (exp_a) begin
            total++;
            if (sel !== 3'd5) begin
               bad++;
               $display("FAIL single_sel_t%0d: sel=%0d, required 5", k, sel);
            end
         end
         if (done) done_cnt++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (done_cnt != 1) begin
         bad++;
         $display("FAIL single_done_count: got %0d pulses, required 1", done_cnt);
      end
   endtask

   task automatic test_burst();
      logic [3:0] reqs [6];
      logic [3:0] exp_drv;
      int   acc = 0, nxt = 0, ndrv = 0, last_done = -1;
      bit   full_seen = 1'b0;
      logic prev_act = 1'b0;
      reqs = '{4'b1_001, 4'b0_110, 4'b1_111, 4'b1_010, 4'b0_100, 4'b1_101};
      @(posedge clk); #1;
      for (int c = 0; c < 60; c++) begin
         if (c == 0) begin
            in_valid = 1'b1;
            {in_data, in_sel} = 4'b1_011;
         end else if (c >= 2 && nxt < 6) begin
            in_valid = 1'b1;
            {in_data, in_sel} = reqs[nxt];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c >= 2 && in_valid) begin
            if (!in_ready && !full_seen) begin
               full_seen = 1'b1;
               total++;
               if (acc != 4) begin
                  bad++;
                  $display("FAIL burst_full_point: in_ready dropped after %0d accepts, required 4",
                           acc);
               end
            end
            if (in_ready) begin
               acc++;
               nxt++;
            end
         end
         if (drv_active && !prev_act) begin
            if (ndrv < 7) begin
               exp_drv = (ndrv == 0) ? 4'b1_011 : reqs[ndrv-1];
               total++;
               if ({a, sel} !== exp_drv) begin
                  bad++;
                  $display("FAIL burst_order_%0d: a=%b sel=%0d, required a=%b sel=%0d",
                           ndrv, a, sel, exp_drv[3], exp_drv[2:0]);
               end
            end
            ndrv++;
         end
         prev_act = drv_active;
         if (done) begin
            if (last_done >= 0) begin
               total++;
               if (c - last_done != 6) begin
                  bad++;
                  $display("FAIL burst_period: %0d cycles between done pulses, required 6",
                           c - last_done);
               end
            end
            last_done = c;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (ndrv != 7 || acc != 6 || !full_seen) begin
         bad++;
         $display("FAIL burst_totals: drives=%0d accepts=%0d full_seen=%b, required 7 6 1",
                  ndrv, acc, full_seen);
      end
   endtask

   task automatic test_scan();
      logic [3:0] exp_seq [10];
      int   ndrv = 0, inj = 0, tail_done = 0, tail_starts = 0;
      logic prev_act = 1'b0;
      bit   reached = 1'b0;
      exp_seq = '{4'b1_000, 4'b1_001, 4'b1_010, 4'b1_011, 4'b0_010,
                  4'b1_100, 4'b1_101, 4'b1_110, 4'b1_111, 4'b1_000};
      @(posedge clk); #1 scan_en = 1'b1;
      for (int c = 0; c < 80; c++) begin
         if (!reached) begin
            in_valid = (inj == 1);
            in_data  = 1'b0;
            in_sel   = 3'd2;
            if (inj == 1) inj = 2;
            @(negedge clk);
            if (in_valid) begin
               total++;
               if (in_ready !== 1'b1) begin
                  bad++;
                  $display("FAIL scan_inject_ready: rdy=%b, required 1", in_ready);
               end
            end
            if (drv_active && !prev_act) begin
               total++;
               if ({a, sel} !== exp_seq[ndrv]) begin
                  bad++;
                  $display("FAIL scan_step_%0d: a=%b sel=%0d, required a=%b sel=%0d",
                           ndrv, a, sel, exp_seq[ndrv][3], exp_seq[ndrv][2:0]);
               end
               ndrv++;
               if (ndrv == 4) inj = 1;
               if (ndrv == 10) reached = 1'b1;
            end
            prev_act = drv_active;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      total++;
      if (!reached) begin
         bad++;
         $display("FAIL scan_timeout: saw %0d drive steps, required 10", ndrv);
      end
      scan_en = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) tail_done++;
         if (drv_active && !prev_act) tail_starts++;
         prev_act = drv_active;
         @(posedge clk); #1;
      end
      total++;
      if (tail_done != 1 || tail_starts != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL scan_stop: done=%0d new_steps=%0d busy=%b, required 1 0 0",
                  tail_done, tail_starts, busy);
      end
   endtask

   task automatic test_data0();
      logic exp_act;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k == 0);
         in_data  = 1'b0;
         in_sel   = 3'd7;
         @(negedge clk);
         exp_act = (k >= 2 && k <= 5);
         total++;
         if (a !== 1'b0 || drv_active !== exp_act || done !== (k == 5)) begin
            bad++;
            $display("FAIL data0_t%0d: a=%b act=%b done=%b, required 0 %b %b",
                     k, a, drv_active, done, exp_act, (k == 5));
         end
         if (exp_act) begin
            total++;
            if (sel !== 3'd7) begin
               bad++;
               $display("FAIL data0_sel_t%0d: sel=%0d, required 7", k, sel);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] r [3];
      logic exp_act;
      r = '{4'b1_001, 4'b1_100, 4'b0_110};
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) begin
         v2 = (k < 3);
         if (k < 3) {d2, sel2i} = r[k];
         @(negedge clk);
         exp_act = (k == 2 || k == 4 || k == 6);
         total++;
         if (act2 !== exp_act || done2 !== exp_act) begin
            bad++;
            $display("FAIL b2b_t%0d: act=%b done=%b, required %b %b", k, act2, done2, exp_act, exp_act);
         end
         if (exp_act) begin
            total++;
            if ({a2, sel2} !== r[(k-2)/2]) begin
               bad++;
               $display("FAIL b2b_drive_t%0d: a=%b sel=%0d, required a=%b sel=%0d",
                        k, a2, sel2, r[(k-2)/2][3], r[(k-2)/2][2:0]);
            end
         end else begin
            total++;
            if (a2 !== 1'b0) begin
               bad++;
               $display("FAIL b2b_idle_t%0d: a=%b, required 0", k, a2);
            end
         end
         @(posedge clk); #1;
      end
      v2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_sel = 3'd0; scan_en = 1'b0;
      v2 = 1'b0; d2 = 1'b0; sel2i = 3'd0; scan2 = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_scan();
      test_data0();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
